// File: rtl/pc_sequencer.sv
// PC sequencer for the 9-bit CPU: owns pc, runs fetch/exec,
// resolves relative branches and counts retired instructions.
module pc_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             imem_req,
  output logic [7:0]       imem_addr,
  input  logic             imem_ack,
  input  logic [8:0]       instr,
  output logic [8:0]       ir,
  input  logic [1:0]       br_type,
  input  logic             br_dir,
  input  logic [3:0]       br_off,
  input  logic [7:0]       r_val,
  input  logic             halt_i,
  input  logic             stall,
  output logic [7:0]       pc,
  output logic             exec_valid,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0] state;
  logic       taken;
  logic [7:0] off;
  logic [7:0] br_pc;
  logic [7:0] next_pc;

  always_comb begin
    taken = 1'b0;
    unique case (br_type)
      2'b00: taken = 1'b0;
      2'b01: taken = 1'b1;
      2'b10: taken = (r_val == 8'd0);
      2'b11: taken = (r_val != 8'd0);
      default: taken = 1'b0;
    endcase
  end

  // offset is stored in half units; arithmetic wraps mod 256
  assign off     = {3'b000, br_off, 1'b0};
  assign br_pc   = br_dir ? (pc - off) : (pc + off);
  assign next_pc = taken ? br_pc : (pc + 8'd1);

  assign imem_req   = (state == S_FETCH);
  assign imem_addr  = pc;
  assign exec_valid = (state == S_EXEC) && !stall;
  assign busy       = (state == S_FETCH) || (state == S_EXEC);
  assign halted     = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= 8'd0;
      ir      <= 9'd0;
      retired <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state   <= S_FETCH;
            pc      <= 8'd0;
            retired <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir    <= instr;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            if (retired != '1)
              retired <= retired + CNT_W'(1);
            if (halt_i) begin
              state <= S_HALT;
            end else begin
              pc    <= next_pc;
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed instruction stream,
// expected retirements queued and checked by an exec_valid monitor.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        imem_ack;
  logic [8:0]  instr;
  logic [1:0]  br_type;
  logic        br_dir;
  logic [3:0]  br_off;
  logic [7:0]  r_val;
  logic        halt_i;
  logic        stall;

  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [8:0]  ir;
  logic [7:0]  pc;
  logic        exec_valid;
  logic        busy;
  logic        halted;
  logic [15:0] retired;

  logic        imem_req2;
  logic [7:0]  imem_addr2;
  logic [8:0]  ir2;
  logic [7:0]  pc2;
  logic        exec_valid2;
  logic        busy2;
  logic        halted2;
  logic [1:0]  retired2;

  pc_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .instr(instr), .ir(ir),
    .br_type(br_type), .br_dir(br_dir), .br_off(br_off),
    .r_val(r_val), .halt_i(halt_i), .stall(stall),
    .pc(pc), .exec_valid(exec_valid), .busy(busy),
    .halted(halted), .retired(retired)
  );

  pc_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack), .instr(instr), .ir(ir2),
    .br_type(br_type), .br_dir(br_dir), .br_off(br_off),
    .r_val(r_val), .halt_i(halt_i), .stall(stall),
    .pc(pc2), .exec_valid(exec_valid2), .busy(busy2),
    .halted(halted2), .retired(retired2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  pc;
    logic [8:0]  ir;
    logic [15:0] ret;
    logic [1:0]  ret2;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int ret_m = 0;
  int ev_seen = 0;
  int ev_exp = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] sat2(input int n);
    return (n > 3) ? 2'd3 : n[1:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (exec_valid === 1'b1) begin
      ev_seen++;
      if (q.size() == 0) begin
        chk("exec_valid_unexpected", {31'b0, exec_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("mon_pc", {24'b0, pc}, {24'b0, e.pc});
        chk("mon_ir", {23'b0, ir}, {23'b0, e.ir});
        chk("mon_retired", {16'b0, retired}, {16'b0, e.ret});
        chk("mon_retired2", {30'b0, retired2}, {30'b0, e.ret2});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_decoder();
    // junk on decoder inputs outside EXEC must have no effect
    br_type = 2'b01;
    br_dir  = 1'b1;
    br_off  = 4'hF;
    r_val   = 8'h00;
    halt_i  = 1'b1;
    stall   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    ret_m = 0;
    chk("start_req", {31'b0, imem_req}, 32'd1);
    chk("start_pc", {24'b0, pc}, 32'd0);
    chk("start_retired", {16'b0, retired}, 32'd0);
    chk("start_busy", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_fetch();
    int k;
    k = 0;
    while (imem_req !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("fetch_timeout", {31'b0, imem_req}, 32'd1);
  endtask

  task automatic run(input logic [8:0] iw, input int fw, input int ns,
                     input logic [1:0] bt, input logic bd,
                     input logic [3:0] bo, input logic [7:0] rv,
                     input logic hlt, input logic [7:0] exp_pc,
                     input logic [7:0] exp_next);
    int t0;
    wait_fetch();
    chk("imem_addr", {24'b0, imem_addr}, {24'b0, exp_pc});
    q.push_back('{exp_pc, iw, ret_m[15:0], sat2(ret_m)});
    ev_exp++;
    t0 = cyc;
    for (int i = 0; i < fw; i++) begin
      imem_ack = 1'b0;
      tick();
      chk("fetch_wait_pc", {24'b0, pc}, {24'b0, exp_pc});
      chk("fetch_wait_ev", {31'b0, exec_valid}, 32'd0);
    end
    imem_ack = 1'b1;
    instr = iw;
    tick();
    imem_ack = 1'b0;
    instr = 9'h000;
    chk("ir_latched", {23'b0, ir}, {23'b0, iw});
    br_type = bt;
    br_dir  = bd;
    br_off  = bo;
    r_val   = rv;
    halt_i  = hlt;
    stall   = (ns > 0);
    for (int i = 0; i < ns; i++) begin
      tick();
      chk("stall_pc", {24'b0, pc}, {24'b0, exp_pc});
      chk("stall_ir", {23'b0, ir}, {23'b0, iw});
      chk("stall_ret", {16'b0, retired}, ret_m);
    end
    stall = 1'b0;
    tick();
    idle_decoder();
    ret_m++;
    chk("next_pc", {24'b0, pc}, {24'b0, exp_next});
    chk("retired", {16'b0, retired}, ret_m);
    chk("instr_cycles", cyc - t0, fw + ns + 2);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    imem_ack = 1'b0;
    instr = 9'h000;
    idle_decoder();
    tick();
    tick();
    reset = 1'b0;
    chk("rst_pc", {24'b0, pc}, 32'd0);
    chk("rst_ir", {23'b0, ir}, 32'd0);
    chk("rst_ret", {16'b0, retired}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    tick();
    chk("idle_stays", {31'b0, imem_req}, 32'd0);

    // five straight-line instructions
    do_start();
    for (int i = 0; i < 5; i++)
      run(9'h100 + 9'(i), 0, 0, 2'b00, 1'b0, 4'd0, 8'd0, 1'b0,
          8'(i), 8'(i + 1));
    chk("five_ret", {16'b0, retired}, 32'd5);
    chk("five_ret2_sat", {30'b0, retired2}, 32'd3);
    chk("five_pc", {24'b0, pc}, 32'd5);

    // halt beats a taken branch
    run(9'h1FF, 0, 0, 2'b01, 1'b0, 4'd3, 8'd0, 1'b1, 8'h05, 8'h05);
    chk("halt1_halted", {31'b0, halted}, 32'd1);
    chk("halt1_busy", {31'b0, busy}, 32'd0);
    tick();
    chk("halt_hold_pc", {24'b0, pc}, 32'h05);
    chk("halt_hold_ir", {23'b0, ir}, 32'h1FF);

    // conditional branches from 0x10
    do_start();
    run(9'h011, 0, 0, 2'b01, 1'b0, 4'd8, 8'd0, 1'b0, 8'h00, 8'h10);
    run(9'h012, 0, 0, 2'b10, 1'b0, 4'd3, 8'h00, 1'b0, 8'h10, 8'h16);
    run(9'h013, 0, 0, 2'b01, 1'b1, 4'd3, 8'h00, 1'b0, 8'h16, 8'h10);
    run(9'h014, 0, 0, 2'b10, 1'b0, 4'd3, 8'h01, 1'b0, 8'h10, 8'h11);
    run(9'h015, 0, 0, 2'b00, 1'b0, 4'd0, 8'h00, 1'b1, 8'h11, 8'h11);
    do_start();
    run(9'h021, 0, 0, 2'b01, 1'b0, 4'd8, 8'd0, 1'b0, 8'h00, 8'h10);
    run(9'h022, 0, 0, 2'b11, 1'b0, 4'd3, 8'h01, 1'b0, 8'h10, 8'h16);
    run(9'h023, 0, 0, 2'b11, 1'b0, 4'd3, 8'h00, 1'b0, 8'h16, 8'h17);
    run(9'h024, 0, 0, 2'b01, 1'b0, 4'd0, 8'h00, 1'b0, 8'h17, 8'h17);
    run(9'h025, 0, 0, 2'b01, 1'b0, 4'd3, 8'h00, 1'b0, 8'h17, 8'h1D);
    run(9'h026, 0, 0, 2'b00, 1'b0, 4'd0, 8'h00, 1'b1, 8'h1D, 8'h1D);

    // wrap-around in both directions
    do_start();
    run(9'h031, 0, 0, 2'b00, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, 8'h01);
    run(9'h032, 0, 0, 2'b00, 1'b0, 4'd0, 8'h00, 1'b0, 8'h01, 8'h02);
    run(9'h033, 0, 0, 2'b01, 1'b1, 4'd2, 8'h00, 1'b0, 8'h02, 8'hFE);
    run(9'h034, 0, 0, 2'b00, 1'b0, 4'd0, 8'h00, 1'b0, 8'hFE, 8'hFF);
    run(9'h035, 0, 0, 2'b00, 1'b0, 4'd0, 8'h00, 1'b0, 8'hFF, 8'h00);

    // fetch waits and stalls, with start held high throughout
    start = 1'b1;
    run(9'h041, 3, 2, 2'b00, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, 8'h01);
    start = 1'b0;

    // stall together with halt: halt only when stall drops
    run(9'h042, 0, 2, 2'b01, 1'b0, 4'd15, 8'h00, 1'b0, 8'h01, 8'h1F);
    run(9'h043, 0, 0, 2'b00, 1'b0, 4'd0, 8'h00, 1'b0, 8'h1F, 8'h20);
    run(9'h044, 0, 1, 2'b01, 1'b0, 4'd3, 8'h00, 1'b1, 8'h20, 8'h20);
    chk("halt2_halted", {31'b0, halted}, 32'd1);
    chk("halt2_pc", {24'b0, pc}, 32'h20);
    do_start();

    // reset while stalled in EXEC
    run(9'h051, 0, 0, 2'b00, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, 8'h01);
    run(9'h052, 0, 0, 2'b00, 1'b0, 4'd0, 8'h00, 1'b0, 8'h01, 8'h02);
    wait_fetch();
    imem_ack = 1'b1;
    instr = 9'h1AB;
    tick();
    imem_ack = 1'b0;
    stall = 1'b1;
    halt_i = 1'b0;
    tick();
    reset = 1'b1;
    imem_ack = 1'b1;
    tick();
    reset = 1'b0;
    imem_ack = 1'b0;
    stall = 1'b0;
    ret_m = 0;
    chk("mid_rst_pc", {24'b0, pc}, 32'd0);
    chk("mid_rst_ir", {23'b0, ir}, 32'd0);
    chk("mid_rst_ret", {16'b0, retired}, 32'd0);
    chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
    chk("mid_rst_ev", {31'b0, exec_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_halted", {31'b0, halted}, 32'd0);
    tick();
    chk("mid_rst_idle", {31'b0, busy}, 32'd0);
    do_start();
    run(9'h061, 0, 0, 2'b00, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, 8'h01);

    tick();
    chk("queue_empty", q.size(), 32'd0);
    chk("exec_valid_count", ev_seen, ev_exp);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the 9-bit CPU. It owns the 8-bit PC and a fetch/execute state machine, and handshakes with instruction memory. It resolves relative branches (unconditional, jump-if-zero, jump-if-nonzero) against a register operand. It also retires instructions and counts them. It sits between instruction memory, the decoder and the register file, and it is the sole writer of the PC.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter (saturating)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin or restart execution from PC 0 (honoured in IDLE and HALT only)
- imem_req  out  1  fetch request, high for the whole FETCH state
- imem_addr  out  8  fetch address, always equal to pc
- imem_ack  in  1  instruction memory returns instr this cycle (ignored outside FETCH)
- instr  in  9  instruction word from memory
- ir  out  9  latched instruction register, feeds decoder
- br_type  in  2  from decoder: 00 none, 01 unconditional, 10 jizr (taken if r_val==0), 11 jnzr (taken if r_val!=0)
- br_dir  in  1  0 forward, 1 backward
- br_off  in  4  branch offset v
- r_val  in  8  register operand tested by jizr/jnzr
- halt_i  in  1  decoded halt instruction
- stall  in  1  hold EXEC (datapath not ready)
- pc  out  8  current program counter
- exec_valid  out  1  instruction retires this cycle (EXEC && !stall), combinational
- busy  out  1  state is FETCH or EXEC
- halted  out  1  state is HALT
- retired  out  CNT_W  count of retired instructions, saturates at all-ones

## Operation
- States: IDLE, FETCH, EXEC, HALT. Reset → IDLE.
- IDLE: when start=1 → FETCH, pc←0, retired←0.
- FETCH: imem_req=1. When imem_ack=1, ir←instr and → EXEC. Otherwise stay in FETCH with no timeout.
- EXEC: if stall=1, hold all state. Otherwise exec_valid=1, retired increments (saturating), and then:
  - halt_i=1: pc unchanged, → HALT. Halt takes priority over any branch.
  - else taken branch: pc←pc+{3'b0,br_off,1'b0} (fwd) or pc−{3'b0,br_off,1'b0} (back), → FETCH.
  - else (br_type 00, or condition false): pc←pc+1, → FETCH.
- Branch offset is v×2, range 0..30. br_off=0 taken leaves pc unchanged and re-executes the same address.
- All PC arithmetic is 8-bit modulo 256: 0xFF+1→0x00; 0x02−4→0xFE; 0xF8+6→0xFE.
- HALT: pc and ir hold, halted=1. start=1 → FETCH with pc←0 and retired←0.
- start is ignored in FETCH and EXEC.
- Decoder inputs are sampled only in EXEC. Their values in other states have no effect.

## Timing
- Reset values: pc=0, ir=0, retired=0, imem_req=0, exec_valid=0, busy=0, halted=0, state IDLE.
- Reset asserted mid-operation: the next edge forces all of the above regardless of stall/ack.
- Minimum 2 cycles per instruction: FETCH with same-cycle ack, then EXEC with no stall.
- Each FETCH wait cycle and each stall cycle adds exactly 1 cycle.
- Latencies:
  - start→imem_req high: 1 cycle.
  - imem_ack→ir valid: next cycle.
  - pc updates on the edge that ends a non-stalled EXEC.
  - imem_addr shows the new pc in the following FETCH.
- exec_valid is high for exactly one cycle per retired instruction. It is never high in FETCH, IDLE or HALT.
- retired is visible as incremented from the cycle after exec_valid.
- Simultaneous stall=1 and halt_i=1: stall wins, and halt is taken only when stall drops.

## Test plan
- Reset then start; ack every FETCH with no branches for 5 instrs → imem_addr sequence 0,1,2,3,4; exec_valid pulses every 2nd cycle; retired=5; pc=5.
- pc=0x10, EXEC with br_type=10, br_dir=0, br_off=3, r_val=0 → pc=0x16. Same with r_val=0x01 → pc=0x11. Repeat with jnzr and r_val=0x01 → pc=0x16.
- pc=0x02, unconditional backward br_off=2 → pc=0xFE. pc=0xFF with no branch → pc=0x00.
- Hold imem_ack=0 for 3 cycles, then hold stall=1 for 2 cycles in EXEC → instruction takes 7 cycles total; pc, ir and retired are unchanged during the waits; exactly one exec_valid pulse.
- halt_i=1 together with taken branch at pc=0x20 → HALT, pc=0x20, halted=1. start ignored while busy; start in HALT → FETCH at 0x00 with retired=0.
- Assert reset during EXEC with stall=1 → next cycle all outputs are at reset values and state is IDLE. Retired counter with CNT_W=2 saturates at 3 after 5 instructions.
